// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        UP     = 2'd0,
        CHK_DN = 2'd1,
        DOWN   = 2'd2,
        CHK_UP = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ          = 27_000_000;
    // 10 ms qualification window and 1 s long-press threshold.
    localparam int unsigned DB_CYCLES_DEF   = CLK_HZ / 100;
    localparam int unsigned LONG_CYCLES_DEF = CLK_HZ;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronize, debounce, press/release strobes and press counter.
// Optional hold timer with long_press strobe is built when BTN_LONG_PRESS_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_state,
    output logic       press,
    output logic       btn_release,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    // The qualifying cycle itself is counted by the transition, so the last count is DB_CYCLES-2.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 2);

    logic pin_sync;
    logic raw;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (pin_sync)
    );

    assign raw = ACTIVE_LOW ? ~pin_sync : pin_sync;

    btn_state_t      state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_d, release_d, held_d;
    logic            press_q, release_q, btn_state_q;
    logic [7:0]      press_count_q, press_count_d;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            UP: begin
                if (raw) begin
                    state_d  = CHK_DN;
                    db_cnt_d = '0;
                end
            end
            CHK_DN: begin
                if (!raw) begin
                    state_d  = UP;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = DOWN;
                    db_cnt_d = '0;
                    press_d  = 1'b1;
                end else if (db_cnt_q != '1) begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (!raw) begin
                    state_d  = CHK_UP;
                    db_cnt_d = '0;
                end
            end
            CHK_UP: begin
                if (raw) begin
                    state_d  = DOWN;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = UP;
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                end else if (db_cnt_q != '1) begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = UP;
                db_cnt_d = '0;
            end
        endcase
    end

    assign held_d        = (state_d == DOWN) || (state_d == CHK_UP);
    assign press_count_d = press_d ? press_count_q + 8'd1 : press_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= UP;
            db_cnt_q      <= '0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            btn_state_q   <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            press_q       <= press_d;
            release_q     <= release_d;
            btn_state_q   <= held_d;
            press_count_q <= press_count_d;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Saturation at HOLD_MAX is what limits long_press to one strobe per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (held_d && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0 & (LONG_CYCLES > DB_CYCLES);
`endif

    assign btn_state   = btn_state_q;
    assign press       = press_q;
    assign btn_release = release_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: strobes are predicted from pin timing and popped on arrival.
module tb_btn_debounce;

    localparam int DB   = 8;
    localparam int LONG = 32;
    localparam int LAT  = DB + 2;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    localparam logic [2:0] K_PRESS = 3'b100;
    localparam logic [2:0] K_REL   = 3'b010;
    localparam logic [2:0] K_LONG  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        int         cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b1;
    logic       btn_state, press, btn_release, long_press;
    logic [7:0] press_count;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_press = 0;
    logic [7:0] exp_cnt = 8'd0;
    ev_t        sb_q[$];
    ev_t        ev;
    logic [2:0] seen;

    btn_debounce #(
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_state   (btn_state),
        .press       (press),
        .btn_release (btn_release),
        .long_press  (long_press),
        .press_count (press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", tag, cyc, got, want);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] kind, input int at, input logic [7:0] cnt);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.cnt  = int'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        goto(cyc + 1);
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    // Press the pin for `hold` cycles then release; predicts press, optional long, release.
    task automatic press_hold(input int hold);
        int c0;
        c0 = cyc;
        btn_in = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        push(K_PRESS, c0 + LAT, exp_cnt);
        if (LONG_EN && hold > LONG) push(K_LONG, c0 + LAT + LONG, exp_cnt);
        push(K_REL, c0 + hold + LAT, exp_cnt);
        goto(c0 + LAT - 1);
        @(negedge clk) check("state_before_press", btn_state, 0);
        goto(c0 + LAT);
        @(negedge clk) check("state_at_press", btn_state, 1);
        goto(c0 + hold);
        btn_in = 1'b1;
        goto(c0 + hold + LAT - 1);
        @(negedge clk) check("state_before_release", btn_state, 1);
        goto(c0 + hold + LAT);
        @(negedge clk) check("state_at_release", btn_state, 0);
        goto(c0 + hold + LAT + 4);
    endtask

    always @(negedge clk) begin
        seen = {press, btn_release, long_press};
        if (seen != 3'b000) begin
            if (press) n_press++;
            if (sb_q.size() == 0) begin
                check("spurious_strobe", int'(seen), 0);
            end else begin
                ev = sb_q.pop_front();
                $display("event kind=%b cycle=%0d count=%0d", seen, cyc, press_count);
                check("strobe_kind", int'(seen), int'(ev.kind));
                check("strobe_cycle", cyc, ev.cyc);
                check("strobe_count", int'(press_count), ev.cnt);
            end
        end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
            ev = sb_q.pop_front();
            check("missing_strobe", cyc, ev.cyc);
        end
    end

    initial begin
        int c0;
        int base;

        goto(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", btn_state, 0);
        check("rst_press", press, 0);
        check("rst_release", btn_release, 0);
        check("rst_long", long_press, 0);
        check("rst_count", press_count, 0);
        goto(cyc + 4);

        // Clean press held 20 cycles: no long press expected.
        press_hold(20);
        check("count_after_press", press_count, 1);

        // Bounce: 3-cycle low/high segments never qualify.
        for (int i = 0; i < 10; i++) begin
            btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            goto(cyc + 3);
            check("bounce_state", btn_state, 0);
        end
        goto(cyc + 15);
        check("bounce_state_end", btn_state, 0);
        check("bounce_count", press_count, 1);

        // Long press held 60 cycles.
        press_hold(60);
        check("count_after_long", press_count, 2);

        reset_dut();
        @(negedge clk);
        check("reset_count", press_count, 0);
        goto(cyc + 3);

        // 256 presses wrap the counter back to zero.
        base = n_press;
        for (int i = 0; i < 256; i++) press_hold(12);
        check("wrap_count", press_count, 0);
        check("wrap_pulses", n_press - base, 256);

        // Reset while held: no release, then a fresh press after reset.
        c0 = cyc;
        btn_in = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        push(K_PRESS, c0 + LAT, exp_cnt);
        goto(c0 + LAT + 5);
        check("held_before_rst", btn_state, 1);
        reset_dut();
        @(negedge clk);
        check("midrst_state", btn_state, 0);
        check("midrst_count", press_count, 0);
        check("midrst_release", btn_release, 0);
        c0 = cyc;
        exp_cnt = exp_cnt + 8'd1;
        push(K_PRESS, c0 + LAT, exp_cnt);
        goto(c0 + LAT);
        @(negedge clk) check("repress_state", btn_state, 1);
        btn_in = 1'b1;
        goto(cyc + 1);
        push(K_REL, cyc - 1 + LAT, exp_cnt);
        goto(cyc + LAT + 4);
        check("final_state", btn_state, 0);
        check("final_count", press_count, 1);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
